// File: rtl/sprite_command_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sprite_command_gen_pkg
// Description : Shared FSM encoding, screen geometry, colour constants and
//               button indices for the sprite command generator.
// Revision    : 1.0 - initial release
// ============================================================================
package sprite_command_gen_pkg;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_EVAL  = 3'd2,
    ST_MOVE  = 3'd3,
    ST_COLOR = 3'd4
  } state_t;

  localparam int C_SCREEN_W = 640;
  localparam int C_SCREEN_H = 480;

  localparam logic [2:0] C_COLOR_WHITE = 3'b111;

  // Positions of each button inside the synchronizer bank.
  localparam int C_BTN_UP    = 0;
  localparam int C_BTN_DOWN  = 1;
  localparam int C_BTN_LEFT  = 2;
  localparam int C_BTN_RIGHT = 3;
  localparam int C_BTN_COLOR = 4;
  localparam int C_BTN_HOME  = 5;
  localparam int C_NUM_BTN   = 6;

  // Colour cycle 1..7 with 7 wrapping back to 1; black (0) is never produced.
  function automatic logic [2:0] next_color(input logic [2:0] cur);
    if (cur == 3'd7 || cur == 3'd0) return 3'd1;
    return cur + 3'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_command_gen_btn_sync.sv
`default_nettype none
// ============================================================================
// Module      : sprite_command_gen_btn_sync
// Description : Two-flop synchronizer for a raw push button, followed by a
//               frame-rate sampler that keeps the current and previous
//               frame's level (sampling once per frame debounces the button).
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_command_gen_btn_sync (
  input  logic Clock,
  input  logic Reset,
  input  logic iBtn,
  input  logic iTick,
  output logic oLevel,
  output logic oPrev
);

  logic meta_q;
  logic sync_q;
  logic level_q;
  logic prev_q;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= iBtn;
      sync_q <= meta_q;
    end
  end

  // Sample once per frame; keep the previous frame's sample for edge detect.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      level_q <= 1'b0;
      prev_q  <= 1'b0;
    end else if (iTick) begin
      level_q <= sync_q;
      prev_q  <= level_q;
    end
  end

  assign oLevel = level_q;
  assign oPrev  = prev_q;

endmodule
`default_nettype wire

// File: rtl/sprite_command_gen.sv
`default_nettype none
// ============================================================================
// Module      : sprite_command_gen
// Description : Turns push-button input into sprite position and colour
//               commands, at most one of each per frame, issued during
//               vertical blank and clamped so the sprite stays on screen.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_command_gen
  import sprite_command_gen_pkg::*;
#(
  parameter int         STEP          = 2,
  parameter int         SCREEN_W      = C_SCREEN_W,
  parameter int         SCREEN_H      = C_SCREEN_H,
  parameter int         SPR_SIZE      = 16,
  parameter logic [4:0] HOME_X        = 5'd9,
  parameter logic [4:0] HOME_Y        = 5'd7,
  parameter int         REPEAT_FRAMES = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [9:0] iColumnCount,
  input  logic [9:0] iRowCount,
  input  logic [9:0] iPosX,
  input  logic       iBtnUp,
  input  logic       iBtnDown,
  input  logic       iBtnLeft,
  input  logic       iBtnRight,
  input  logic       iBtnColor,
  input  logic       iBtnHome,
  output logic       oChangePos,
  output logic       oAbsolute,
  output logic [4:0] oSetX,
  output logic [4:0] oSetY,
  output logic [2:0] oNewColor,
  output logic       oSetColor,
  output logic [9:0] oPosY
);

  localparam int         REP_W   = $clog2(REPEAT_FRAMES) + 1;
  localparam logic [9:0] C_XMAX  = 10'(SCREEN_W - SPR_SIZE);
  localparam logic [9:0] C_YMAX  = 10'(SCREEN_H - SPR_SIZE);
  localparam logic [9:0] C_STEP  = 10'(STEP);

  // ---------------- frame tick: first cycle of the blank-start condition
  logic w_tick_cond;
  logic cond_q;
  logic w_tick;

  assign w_tick_cond = (iRowCount == 10'(SCREEN_H)) && (iColumnCount == 10'd0);
  assign w_tick      = w_tick_cond && !cond_q;

  // Delay the condition so a counter that stalls yields only one tick.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) cond_q <= 1'b0;
    else       cond_q <= w_tick_cond;
  end

  // ---------------- button synchronizers
  logic [C_NUM_BTN-1:0] w_raw;
  logic [C_NUM_BTN-1:0] w_lvl;
  logic [C_NUM_BTN-1:0] w_prev;
  logic [C_NUM_BTN-1:0] w_press;

  assign w_raw   = {iBtnHome, iBtnColor, iBtnRight, iBtnLeft, iBtnDown, iBtnUp};
  assign w_press = w_lvl & ~w_prev;

  generate
    for (genvar gi = 0; gi < C_NUM_BTN; gi++) begin : g_btn
      sprite_command_gen_btn_sync u_sync (
        .Clock  (Clock),
        .Reset  (Reset),
        .iBtn   (w_raw[gi]),
        .iTick  (w_tick),
        .oLevel (w_lvl[gi]),
        .oPrev  (w_prev[gi])
      );
    end
  endgenerate

  // ---------------- state
  state_t           state_q;
  logic             init_q;
  logic             col_pend_q;
  logic [REP_W-1:0] rep_q;
  logic [2:0]       color_q;
  logic [9:0]       pos_y_q;
  logic             change_pos_q;
  logic             absolute_q;
  logic [4:0]       set_x_q;
  logic [4:0]       set_y_q;
  logic             set_color_q;
  logic [2:0]       new_color_q;

  // ---------------- clamped offsets and move decision
  logic [9:0] w_x_room, w_y_room;
  logic [4:0] w_dx, w_dy;
  logic       w_any_dir, w_fire, w_move;
  logic [2:0] color_d;
  logic [9:0] pos_y_d;

  // Offsets limited to the distance left to each screen edge.
  always_comb begin
    w_x_room = 10'd0;
    w_y_room = 10'd0;
    if (iPosX < C_XMAX)   w_x_room = C_XMAX - iPosX;
    if (pos_y_q < C_YMAX) w_y_room = C_YMAX - pos_y_q;
    w_dx = 5'd0;
    w_dy = 5'd0;
    if (w_lvl[C_BTN_LEFT] && !w_lvl[C_BTN_RIGHT])
      w_dx = 5'd0 - ((iPosX < C_STEP) ? iPosX[4:0] : 5'(STEP));
    else if (w_lvl[C_BTN_RIGHT] && !w_lvl[C_BTN_LEFT])
      w_dx = (w_x_room < C_STEP) ? w_x_room[4:0] : 5'(STEP);
    if (w_lvl[C_BTN_UP] && !w_lvl[C_BTN_DOWN])
      w_dy = 5'd0 - ((pos_y_q < C_STEP) ? pos_y_q[4:0] : 5'(STEP));
    else if (w_lvl[C_BTN_DOWN] && !w_lvl[C_BTN_UP])
      w_dy = (w_y_room < C_STEP) ? w_y_room[4:0] : 5'(STEP);
  end

  assign w_any_dir = |w_lvl[C_BTN_RIGHT:C_BTN_UP];
  assign w_fire    = (|w_press[C_BTN_RIGHT:C_BTN_UP]) ||
                     (w_any_dir && (rep_q == REP_W'(REPEAT_FRAMES - 1)));
  assign w_move    = w_fire && ((w_dx != 5'd0) || (w_dy != 5'd0));
  assign color_d   = init_q ? C_COLOR_WHITE : next_color(color_q);
  assign pos_y_d   = pos_y_q + {{5{w_dy[4]}}, w_dy};

  // Command FSM; strobes and payloads are registered and last one cycle.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_INIT;
      init_q       <= 1'b1;
      col_pend_q   <= 1'b0;
      rep_q        <= '0;
      color_q      <= 3'd0;
      pos_y_q      <= 10'd0;
      change_pos_q <= 1'b0;
      absolute_q   <= 1'b0;
      set_x_q      <= 5'd0;
      set_y_q      <= 5'd0;
      set_color_q  <= 1'b0;
      new_color_q  <= 3'd0;
    end else begin
      change_pos_q <= 1'b0;
      absolute_q   <= 1'b0;
      set_x_q      <= 5'd0;
      set_y_q      <= 5'd0;
      set_color_q  <= 1'b0;
      new_color_q  <= 3'd0;
      case (state_q)
        ST_INIT, ST_IDLE: begin
          if (w_tick) state_q <= ST_EVAL;
        end
        ST_EVAL: begin
          col_pend_q <= w_press[C_BTN_COLOR];
          if (init_q || w_press[C_BTN_HOME]) begin
            // Home: absolute command; the first frame after reset also
            // forces the white colour command that follows it.
            change_pos_q <= 1'b1;
            absolute_q   <= 1'b1;
            set_x_q      <= HOME_X;
            set_y_q      <= HOME_Y;
            pos_y_q      <= {HOME_Y, 5'd0};
            if (init_q) col_pend_q <= 1'b1;
            else        rep_q      <= '0;
            state_q <= ST_MOVE;
          end else begin
            if (!w_any_dir || w_fire) rep_q <= '0;
            else                      rep_q <= rep_q + REP_W'(1);
            if (w_move) begin
              change_pos_q <= 1'b1;
              set_x_q      <= w_dx;
              set_y_q      <= w_dy;
              pos_y_q      <= pos_y_d;
              state_q      <= ST_MOVE;
            end else if (w_press[C_BTN_COLOR]) begin
              set_color_q <= 1'b1;
              new_color_q <= color_d;
              color_q     <= color_d;
              state_q     <= ST_COLOR;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_MOVE: begin
          if (col_pend_q) begin
            set_color_q <= 1'b1;
            new_color_q <= color_d;
            color_q     <= color_d;
            init_q      <= 1'b0;
            state_q     <= ST_COLOR;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign oChangePos = change_pos_q;
  assign oAbsolute  = absolute_q;
  assign oSetX      = set_x_q;
  assign oSetY      = set_y_q;
  assign oSetColor  = set_color_q;
  assign oNewColor  = new_color_q;
  assign oPosY      = pos_y_q;

endmodule
`default_nettype wire

// File: doc/sprite_command_gen.md
Name: sprite_command_gen

Overview:
Command initiator for the 16x16 sprite block. Drives the sprite's position and colour command port (change-pos, absolute, set-X/Y, new-colour, set-colour) from push-button inputs. Issues at most one position command and one colour command per frame, always during vertical blank. Clamps every move so the sprite stays fully on screen.

Parameters:
STEP, 2, per-frame move magnitude in pixels; legal range 1..15 (fits a signed 5-bit offset).
SCREEN_W, 640, visible width in pixels.
SCREEN_H, 480, visible height in pixels.
SPR_SIZE, 16, sprite edge length in pixels.
HOME_X, 5'd9, absolute X coarse position; pixel X = HOME_X*32.
HOME_Y, 5'd7, absolute Y coarse position; pixel Y = HOME_Y*32.
REPEAT_FRAMES, 4, frames between auto-repeat moves while a direction button is held.

Ports:
Clock  in  1  system clock
Reset  in  1  asynchronous, active-high reset
iColumnCount  in  10  VGA column counter
iRowCount  in  10  VGA row counter
iPosX  in  10  current sprite X, fed back from the sprite
iBtnUp / iBtnDown / iBtnLeft / iBtnRight  in  1 each  raw direction buttons, asynchronous
iBtnColor  in  1  raw colour-cycle button
iBtnHome  in  1  raw return-home button
oChangePos  out  1  one-cycle position-command strobe
oAbsolute  out  1  qualifies oChangePos: 1 = absolute, 0 = relative
oSetX  out  5  X coarse position (absolute) or signed X offset (relative)
oSetY  out  5  Y coarse position (absolute) or signed Y offset (relative)
oNewColor  out  3  colour payload
oSetColor  out  1  one-cycle colour-command strobe
oPosY  out  10  internal mirror of the sprite Y position

Behaviour:
- Reset (async, immediate, also mid-command): all outputs 0, FSM in INIT, colour register 0, repeat counter 0, oPosY 0.
- Button inputs: 2-FF synchronizer each. Synchronized levels are sampled only at the frame tick; frame-rate sampling is the debounce.
- Frame tick:
  - Condition: iRowCount==SCREEN_H and iColumnCount==0.
  - Tick fires on the first cycle the condition is true: condition AND NOT condition-delayed.
  - Exactly one tick per frame, even when the counters hold for several clocks.
- FSM states: INIT, IDLE, EVAL, MOVE, COLOR.
  - INIT: on the first tick after reset, issue an absolute home command (oChangePos=1, oAbsolute=1, oSetX=HOME_X, oSetY=HOME_Y, oPosY=HOME_Y*32). On the next cycle issue a colour command (oSetColor=1, oNewColor=3'b111). Then IDLE.
  - IDLE: on tick -> EVAL.
  - EVAL (1 cycle): compute the command; latch colour edge = sampled colour AND NOT previous sampled colour. Next state MOVE if a position command is pending, else COLOR if a colour edge is pending, else IDLE.
  - MOVE (1 cycle): registered strobe plus payload. oPosY updated in the same cycle. Next state COLOR if a colour edge is pending, else IDLE.
  - COLOR (1 cycle): colour = next value in 1..7, wrapping 7->1 (0 never produced); oSetColor=1. Next state IDLE.
- Latency: oChangePos asserts 2 cycles after the tick cycle; oSetColor asserts 3 cycles after (2 if there is no move). Payloads are valid only while the matching strobe is high and are 0 otherwise.
- Home button:
  - Overrides directions: absolute home command in MOVE, exactly as in INIT.
  - Clears the repeat counter.
  - Colour edge still processed in the same frame.
- Direction moves:
  - Fire on press (sampled 0->1) immediately.
  - While held, fire every REPEAT_FRAMES ticks. The repeat counter resets when no direction is held.
  - Up+Down or Left+Right together: that axis offset = 0.
- Clamping, X axis (uses iPosX):
  - Left: offset = -min(STEP, iPosX).
  - Right: offset = +min(STEP, SCREEN_W-SPR_SIZE-iPosX).
- Clamping, Y axis: same rules using oPosY and SCREEN_H.
- If both offsets are 0 after clamping, no MOVE strobe is issued.
- Offsets are two's complement 5-bit. oPosY += sign-extended dy when MOVE issues.
- A tick arriving while not in IDLE/INIT is ignored (impossible for any sane timing; asserted in the bench).

Decomposition:
- Shared package: FSM state encoding and the tick-condition constants SCREEN_H/SCREEN_W. The colour constants (white = 3'b111) already live in the collaterals.
- One natural sub-module, btn_sync: 2-FF synchronizer plus frame-sampled edge detect, instantiated 6 times.

Test Plan:
- Reset, then first tick -> oChangePos=1, oAbsolute=1, oSetX=9, oSetY=7 at tick+2; oSetColor=1, oNewColor=7 at tick+3; no further strobes in the frame.
- iPosX=100, Right held 9 frames, REPEAT_FRAMES=4 -> relative moves oSetX=+2 on frames 0, 4, 8 only; oSetY=0.
- iPosX=1, Left pressed -> oSetX=5'b11111 (-1); next frame iPosX=0 -> no oChangePos.
- iPosX=623, Right pressed -> oSetX=+1. oPosY=463, Down pressed -> oSetY=+1, oPosY=464.
- Home + Left + Color rising in the same frame -> absolute (9,7) at tick+2, then oSetColor with colour 7->1 wrap at tick+3.
- Row counter holds 480 for 3 clocks at col 0 -> single tick. Reset asserted while in MOVE -> strobe drops the same cycle and FSM returns to INIT.
